// File: rtl/cfu_share_arbiter.sv
// cfu_share_arbiter: round-robin sharing of one single-outstanding CFU between NREQ requesters
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   req_cmd_*               per-requester command channel (valid/ready, packed payloads)
//   req_rsp_*               per-requester response channel; data bus shared, qualified by valid
//   cfu_cmd_*               registered command toward the CFU
//   cfu_rsp_*               response from the CFU
//   timeout_err             one-cycle pulse when the response watchdog expires
//
// Optional feature: define CFU_ARB_WATCHDOG_EN to enable the WAIT_RSP watchdog
// (TIMEOUT_CYCLES), the stale-response drain and timeout_err; otherwise timeout_err is 0.
module cfu_share_arbiter #(
   parameter int NREQ           = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_cmd_valid,
   output logic [NREQ-1:0]    req_cmd_ready,
   input  logic [NREQ*10-1:0] req_cmd_function_id,
   input  logic [NREQ*32-1:0] req_cmd_inputs_0,
   input  logic [NREQ*32-1:0] req_cmd_inputs_1,
   output logic [NREQ-1:0]    req_rsp_valid,
   input  logic [NREQ-1:0]    req_rsp_ready,
   output logic [31:0]        req_rsp_outputs_0,
   output logic               cfu_cmd_valid,
   input  logic               cfu_cmd_ready,
   output logic [9:0]         cfu_cmd_function_id,
   output logic [31:0]        cfu_cmd_inputs_0,
   output logic [31:0]        cfu_cmd_inputs_1,
   input  logic               cfu_rsp_valid,
   output logic               cfu_rsp_ready,
   input  logic [31:0]        cfu_rsp_outputs_0,
   output logic               timeout_err
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RETURN} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] rr_q, rr_d, grant_q, grant_d, pick, idx;
   logic [9:0] fid_q, fid_d;
   logic [31:0] in0_q, in0_d, in1_q, in1_d, res_q, res_d;
   logic found, stale, can_accept;
`ifdef CFU_ARB_WATCHDOG_EN
   logic stale_q, stale_d, terr_q, terr_d;
   logic [7:0] wd_q, wd_d;
   assign stale       = stale_q;
   assign timeout_err = terr_q;
`else
   assign stale       = 1'b0;
   assign timeout_err = 1'b0;
`endif
   // Lowest offset from rr_q wins, so scan offsets downward and let later hits override.
   always_comb begin
      pick  = rr_q;
      idx   = rr_q;
      found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_q) + k) % NREQ);
         if (req_cmd_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
   assign can_accept          = (state_q == IDLE) && !stale && found;
   assign req_cmd_ready       = can_accept ? (NREQ'(1) << pick) : '0;
   assign req_rsp_valid       = (state_q == RETURN) ? (NREQ'(1) << grant_q) : '0;
   assign req_rsp_outputs_0   = res_q;
   assign cfu_cmd_valid       = (state_q == ISSUE);
   assign cfu_cmd_function_id = fid_q;
   assign cfu_cmd_inputs_0    = in0_q;
   assign cfu_cmd_inputs_1    = in1_q;
   // A stale arbiter keeps draining the CFU so the late response cannot be mistaken for a new one.
   assign cfu_rsp_ready       = (state_q == WAIT_RSP) || stale;
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      fid_d   = fid_q;
      in0_d   = in0_q;
      in1_d   = in1_q;
      res_d   = res_q;
`ifdef CFU_ARB_WATCHDOG_EN
      stale_d = stale_q && !cfu_rsp_valid;
      terr_d  = 1'b0;
      wd_d    = wd_q;
`endif
      case (state_q)
         IDLE: if (can_accept) begin
            grant_d = pick;
            fid_d   = req_cmd_function_id[int'(pick)*10 +: 10];
            in0_d   = req_cmd_inputs_0[int'(pick)*32 +: 32];
            in1_d   = req_cmd_inputs_1[int'(pick)*32 +: 32];
            state_d = ISSUE;
         end
         ISSUE: if (cfu_cmd_ready) begin
            state_d = WAIT_RSP;
`ifdef CFU_ARB_WATCHDOG_EN
            wd_d    = '0;
`endif
         end
         WAIT_RSP: if (cfu_rsp_valid) begin
            res_d   = cfu_rsp_outputs_0;
            state_d = RETURN;
         end
`ifdef CFU_ARB_WATCHDOG_EN
         else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
            res_d   = 32'hDEAD_BEEF;
            terr_d  = 1'b1;
            stale_d = 1'b1;
            state_d = RETURN;
         end else begin
            wd_d    = wd_q + 8'd1;
         end
`endif
         RETURN: if (req_rsp_ready[grant_q]) begin
            state_d = IDLE;
            rr_d    = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         fid_q   <= '0;
         in0_q   <= '0;
         in1_q   <= '0;
         res_q   <= '0;
`ifdef CFU_ARB_WATCHDOG_EN
         stale_q <= 1'b0;
         terr_q  <= 1'b0;
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         fid_q   <= fid_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
         res_q   <= res_d;
`ifdef CFU_ARB_WATCHDOG_EN
         stale_q <= stale_d;
         terr_q  <= terr_d;
         wd_q    <= wd_d;
`endif
      end
   end
endmodule

// File: tb/tb_cfu_share_arbiter.sv
// tb_cfu_share_arbiter: randomized and directed checks of cfu_share_arbiter against a transaction-level model
module tb_cfu_share_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_cmd_valid = '0;
   logic [1:0]  req_cmd_ready;
   logic [19:0] req_cmd_function_id = '0;
   logic [63:0] req_cmd_inputs_0 = '0;
   logic [63:0] req_cmd_inputs_1 = '0;
   logic [1:0]  req_rsp_valid;
   logic [1:0]  req_rsp_ready = '0;
   logic [31:0] req_rsp_outputs_0;
   logic        cfu_cmd_valid;
   logic        cfu_cmd_ready = 1'b1;
   logic [9:0]  cfu_cmd_function_id;
   logic [31:0] cfu_cmd_inputs_0, cfu_cmd_inputs_1;
   logic        cfu_rsp_valid = 1'b0;
   logic        cfu_rsp_ready;
   logic [31:0] cfu_rsp_outputs_0 = '0;
   logic        timeout_err;
   int errors = 0;
   int checks = 0;
   int cmd_stall = 0;
   bit cfu_silent = 0;
   bit m_busy = 0;
   int m_rr = 0, m_g = 0, m_age = 0;
   logic [31:0] m_res = '0;
   logic [9:0]  m_fid = '0;
   localparam logic [31:0] A0 = 32'h0102_0304, B0 = 32'h0101_0101;
   localparam logic [31:0] A1 = 32'hFFFF_FFFF, B1 = 32'hFFFF_FFFF;
   cfu_share_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
      .req_cmd_function_id(req_cmd_function_id),
      .req_cmd_inputs_0(req_cmd_inputs_0), .req_cmd_inputs_1(req_cmd_inputs_1),
      .req_rsp_valid(req_rsp_valid), .req_rsp_ready(req_rsp_ready),
      .req_rsp_outputs_0(req_rsp_outputs_0),
      .cfu_cmd_valid(cfu_cmd_valid), .cfu_cmd_ready(cfu_cmd_ready),
      .cfu_cmd_function_id(cfu_cmd_function_id),
      .cfu_cmd_inputs_0(cfu_cmd_inputs_0), .cfu_cmd_inputs_1(cfu_cmd_inputs_1),
      .cfu_rsp_valid(cfu_rsp_valid), .cfu_rsp_ready(cfu_rsp_ready),
      .cfu_rsp_outputs_0(cfu_rsp_outputs_0), .timeout_err(timeout_err)
   );
   always #5 clk = ~clk;
   // 4-lane unsigned byte dot product computed by the attached CFU
   function automatic logic [31:0] dot(logic [31:0] a, logic [31:0] b);
      logic [31:0] s = '0;
      for (int i = 0; i < 4; i++) s += 32'(a[i*8 +: 8]) * 32'(b[i*8 +: 8]);
      return s;
   endfunction
   // Round-robin rule: first valid requester starting at the pointer, nothing while busy
   function automatic logic [1:0] exp_ready(logic [1:0] v);
      if (m_busy) return 2'b00;
      for (int k = 0; k < 2; k++) if (v[(m_rr + k) % 2]) return 2'(1 << ((m_rr + k) % 2));
      return 2'b00;
   endfunction
   // One clock: sample handshakes, advance the reference model and the 1-cycle CFU model
   task automatic step();
      logic [1:0] acc, rf;
      logic cf, crf, rs;
      logic [31:0] a, b;
      #1;
      acc = req_cmd_valid & req_cmd_ready;
      rf  = req_rsp_valid & req_rsp_ready;
      cf  = cfu_cmd_valid & cfu_cmd_ready;
      crf = cfu_rsp_valid & cfu_rsp_ready;
      a   = cfu_cmd_inputs_0;
      b   = cfu_cmd_inputs_1;
      rs  = reset;
      @(posedge clk);
      #1;
      if (rs) begin
         m_busy = 0; m_rr = 0; m_age = 0; cfu_rsp_valid = 0;
      end else begin
         if (rf != 0) begin
            m_busy = 0;
            m_rr = (m_g + 1) % 2;
         end else if (m_busy) m_age++;
         if (acc != 0) begin
            m_g = acc[1] ? 1 : 0;
            m_busy = 1;
            m_age = 0;
            m_res = dot(req_cmd_inputs_0[m_g*32 +: 32], req_cmd_inputs_1[m_g*32 +: 32]);
            m_fid = req_cmd_function_id[m_g*10 +: 10];
         end
         if (crf) cfu_rsp_valid = 0;
         if (cf && !cfu_silent) begin
            cfu_rsp_valid = 1;
            cfu_rsp_outputs_0 = dot(a, b);
         end
      end
      cfu_cmd_ready = !(cfu_cmd_valid && cmd_stall > 0);
      if (!cfu_cmd_ready) cmd_stall--;
   endtask
   task automatic do_reset();
      reset = 1; req_cmd_valid = 0; req_rsp_ready = 0; cmd_stall = 0; cfu_silent = 0;
      step();
      step();
      reset = 0;
   endtask
   task automatic test_reset();
      reset = 1; req_cmd_valid = 0;
      step();
      step();
      checks++;
      if ({req_cmd_ready, req_rsp_valid, cfu_cmd_valid, cfu_rsp_ready, timeout_err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0", {req_cmd_ready, req_rsp_valid, cfu_cmd_valid, cfu_rsp_ready, timeout_err});
      end
      checks++;
      if ({cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1, req_rsp_outputs_0} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h/%h/%h expected 0", cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1, req_rsp_outputs_0);
      end
      reset = 0; req_cmd_valid = 2'b11;
      #1;
      checks++;
      if (req_cmd_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_pick: got %b expected 01", req_cmd_ready);
      end
      req_cmd_valid = 0;
   endtask
   task automatic test_single();
      do_reset();
      req_cmd_valid = 2'b01; req_cmd_function_id = 20'h00003;
      req_cmd_inputs_0 = {32'h0, A0}; req_cmd_inputs_1 = {32'h0, B0}; req_rsp_ready = 2'b11;
      #1;
      checks++;
      if (req_cmd_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_cmd_ready); end
      step();
      req_cmd_valid = 0;
      checks++;
      if ({cfu_cmd_valid, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1} !== {1'b1, 10'h003, A0, B0}) begin
         errors++;
         $display("FAIL single_issue: got %b %h %h %h expected 1 003 %h %h", cfu_cmd_valid, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1, A0, B0);
      end
      step();
      checks++;
      if ({req_rsp_valid, cfu_rsp_ready} !== 3'b001) begin
         errors++;
         $display("FAIL single_wait: got %b expected 001", {req_rsp_valid, cfu_rsp_ready});
      end
      step();
      checks++;
      if (req_rsp_valid !== 2'b01 || req_rsp_outputs_0 !== 32'h0000_000A) begin
         errors++;
         $display("FAIL single_rsp: got %b %h expected 01 0000000a", req_rsp_valid, req_rsp_outputs_0);
      end
      step();
      checks++;
      if (req_rsp_valid !== 2'b00) begin errors++; $display("FAIL single_done: got %b expected 00", req_rsp_valid); end
   endtask
   task automatic test_alternate();
      int n = 0;
      do_reset();
      req_cmd_valid = 2'b11; req_rsp_ready = 2'b11;
      req_cmd_inputs_0 = {A1, A0}; req_cmd_inputs_1 = {B1, B0};
      for (int c = 0; c < 40 && n < 4; c++) begin
         if (req_rsp_valid != 0) begin
            checks++;
            if (req_rsp_valid !== ((n % 2) ? 2'b10 : 2'b01) || req_rsp_outputs_0 !== ((n % 2) ? 32'h0003_F804 : 32'h0000_000A)) begin
               errors++;
               $display("FAIL alternate_%0d: got %b %h expected %b %h", n, req_rsp_valid, req_rsp_outputs_0,
                        (n % 2) ? 2'b10 : 2'b01, (n % 2) ? 32'h0003_F804 : 32'h0000_000A);
            end
            n++;
         end
         step();
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL alternate_count: got %0d responses expected 4", n); end
      req_cmd_valid = 0;
   endtask
   task automatic test_backpressure();
      int c = 0;
      do_reset();
      req_cmd_valid = 2'b11; req_rsp_ready = 2'b00;
      req_cmd_inputs_0 = {A1, A0}; req_cmd_inputs_1 = {B1, B0};
      while (req_rsp_valid == 0 && c < 10) begin step(); c++; end
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (req_rsp_valid !== 2'b01 || req_rsp_outputs_0 !== 32'h0000_000A || req_cmd_ready !== 2'b00) begin
            errors++;
            $display("FAIL hold_%0d: got %b %h rdy %b expected 01 0000000a rdy 00", i, req_rsp_valid, req_rsp_outputs_0, req_cmd_ready);
         end
         step();
      end
      req_rsp_ready = 2'b01;
      step();
      #1;
      checks++;
      if (req_cmd_ready !== 2'b10) begin errors++; $display("FAIL hold_next_grant: got %b expected 10", req_cmd_ready); end
      step();
      req_cmd_valid = 0;
      repeat (4) step();
   endtask
   task automatic test_stall_reset();
      do_reset();
      cmd_stall = 3; cfu_silent = 1;
      req_cmd_valid = 2'b01; req_cmd_function_id = 20'h0015A;
      req_cmd_inputs_0 = {32'h0, 32'h1122_3344}; req_cmd_inputs_1 = {32'h0, 32'h5566_7788};
      step();
      req_cmd_valid = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({cfu_cmd_valid, cfu_cmd_ready, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1} !== {2'b10, 10'h15A, 32'h1122_3344, 32'h5566_7788}) begin
            errors++;
            $display("FAIL stall_%0d: got %b%b %h %h %h expected 10 15a 11223344 55667788", i, cfu_cmd_valid, cfu_cmd_ready,
                     cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1);
         end
         step();
      end
      step();
      checks++;
      if ({cfu_cmd_valid, cfu_rsp_ready} !== 2'b01) begin errors++; $display("FAIL stall_wait: got %b expected 01", {cfu_cmd_valid, cfu_rsp_ready}); end
      step();
      reset = 1;
      step();
      checks++;
      if ({req_cmd_ready, req_rsp_valid, cfu_cmd_valid, cfu_rsp_ready, timeout_err} !== 7'b0) begin
         errors++;
         $display("FAIL midreset_ctrl: got %b expected 0", {req_cmd_ready, req_rsp_valid, cfu_cmd_valid, cfu_rsp_ready, timeout_err});
      end
      reset = 0; cfu_silent = 0; req_cmd_valid = 2'b11;
      #1;
      checks++;
      if (req_cmd_ready !== 2'b01) begin errors++; $display("FAIL midreset_rr: got %b expected 01", req_cmd_ready); end
      req_cmd_valid = 0;
   endtask
   task automatic test_random();
      logic [1:0] ev;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         req_cmd_valid = 2'($urandom);
         req_cmd_function_id = 20'($urandom);
         req_cmd_inputs_0 = {$urandom, $urandom};
         req_cmd_inputs_1 = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         req_rsp_ready = 2'($urandom);
         #1;
         checks++;
         if (req_cmd_ready !== exp_ready(req_cmd_valid)) begin
            errors++;
            $display("FAIL rand_ready@%0d: got %b expected %b", c, req_cmd_ready, exp_ready(req_cmd_valid));
         end
         ev = (m_busy && m_age >= 2) ? 2'(1 << m_g) : 2'b00;
         checks++;
         if (req_rsp_valid !== ev || (ev != 0 && req_rsp_outputs_0 !== m_res)) begin
            errors++;
            $display("FAIL rand_rsp@%0d: got %b %h expected %b %h", c, req_rsp_valid, req_rsp_outputs_0, ev, m_res);
         end
         checks++;
         if (cfu_cmd_valid !== (m_busy && m_age == 0) || (cfu_cmd_valid && cfu_cmd_function_id !== m_fid)) begin
            errors++;
            $display("FAIL rand_cmd@%0d: got %b %h expected %b %h", c, cfu_cmd_valid, cfu_cmd_function_id, m_busy && m_age == 0, m_fid);
         end
         step();
      end
      req_cmd_valid = 0;
   endtask
`ifdef CFU_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      int n = 0;
      do_reset();
      cfu_silent = 1; req_rsp_ready = 2'b00;
      req_cmd_valid = 2'b01; req_cmd_inputs_0 = {A1, A0}; req_cmd_inputs_1 = {B1, B0};
      step();
      req_cmd_valid = 0;
      step();
      while (req_rsp_valid == 0 && n < 20) begin n++; step(); end
      checks++;
      if (n != 4 || req_rsp_valid !== 2'b01 || req_rsp_outputs_0 !== 32'hDEAD_BEEF || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL wd_expire: got wait %0d %b %h terr %b expected 4 01 deadbeef 1", n, req_rsp_valid, req_rsp_outputs_0, timeout_err);
      end
      req_rsp_ready = 2'b01; req_cmd_valid = 2'b10;
      step();
      #1;
      checks++;
      if ({timeout_err, req_rsp_valid, req_cmd_ready, cfu_rsp_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL wd_stale: got %b expected 000001", {timeout_err, req_rsp_valid, req_cmd_ready, cfu_rsp_ready});
      end
      cfu_rsp_valid = 1; cfu_rsp_outputs_0 = 32'h1234_5678;
      step();
      #1;
      checks++;
      if (req_cmd_ready !== 2'b10) begin errors++; $display("FAIL wd_drain: got %b expected 10", req_cmd_ready); end
      cfu_silent = 0; n = 0;
      step();
      req_cmd_valid = 0;
      while (req_rsp_valid == 0 && n < 20) begin n++; step(); end
      checks++;
      if (req_rsp_valid !== 2'b10 || req_rsp_outputs_0 !== 32'h0003_F804) begin
         errors++;
         $display("FAIL wd_recover: got %b %h expected 10 0003f804", req_rsp_valid, req_rsp_outputs_0);
      end
      step();
   endtask
`endif
   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_stall_reset();
      test_random();
`ifdef CFU_ARB_WATCHDOG_EN
      test_watchdog();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
